// File: rtl/adder_rr_arbiter.sv
// Round-robin sequencer sharing one combinational adder among NREQ requesters; IDLE->EXEC->DONE, result valid 2 edges after accept.
// Result held on RES_VALID until RES_READY; no arbitration in EXEC/DONE, so pending requests simply wait.
module adder_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] REQ_A,
  input  logic [NREQ*WIDTH-1:0] REQ_B,
  input  logic [NREQ-1:0]       REQ_CIN,
  output logic [NREQ-1:0]       GNT,
  output logic [WIDTH-1:0]      ADD_A,
  output logic [WIDTH-1:0]      ADD_B,
  output logic                  ADD_CIN,
  output logic                  ADD_EN,
  input  logic [WIDTH-1:0]      ADD_SUM,
  input  logic                  ADD_COUT,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [WIDTH-1:0]      RES_SUM,
  output logic                  RES_COUT,
  output logic [IDW-1:0]        RES_ID,
  output logic                  BUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             found;
  logic [IDW:0]     cand;
  logic [IDW-1:0]   ptr_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

  // Search starts at ptr and wraps modulo NREQ, which need not be a power of two.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && REQ[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    op_a    = REQ_A[int'(win)*WIDTH +: WIDTH];
    op_b    = REQ_B[int'(win)*WIDTH +: WIDTH];
    op_cin  = REQ_CIN[win];
    ptr_nxt = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      GNT       <= '0;
      ADD_A     <= '0;
      ADD_B     <= '0;
      ADD_CIN   <= 1'b0;
      ADD_EN    <= 1'b0;
      RES_VALID <= 1'b0;
      RES_SUM   <= '0;
      RES_COUT  <= 1'b0;
      RES_ID    <= '0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            ADD_A   <= op_a;
            ADD_B   <= op_b;
            ADD_CIN <= op_cin;
            ADD_EN  <= 1'b1;
            RES_ID  <= win;
            GNT     <= NREQ'(1) << win;
            ptr     <= ptr_nxt;
            BUSY    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          GNT       <= '0;
          ADD_EN    <= 1'b0;
          RES_SUM   <= ADD_SUM;
          RES_COUT  <= ADD_COUT;
          RES_VALID <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          GNT    <= '0;
          ADD_EN <= 1'b0;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
